trdb_resync_ctrl: RTL and testbench

TRDB_RESYNC_CTRL -- requirements
Module: trdb_resync_ctrl

---
 rtl/trdb_resync_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_trdb_resync_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_resync_ctrl.sv
// rtl/trdb_resync_ctrl.sv - trace resync request controller (branch-map flush + sync packet)
//
// Purpose:
//   Watches the resync counter status and asks the packetizer for a sync
//   packet when one is owed. Unreported branches are flushed first (format
//   01) so the sync packet (format 11) starts from an empty branch map. A
//   pre-emptive flush is issued one count before the sync becomes due.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   trace_enabled_i       trace qualified by filter; low aborts any request
//   gt_resync_max_i       resync counter at max, sync owed (sampled in IDLE)
//   et_resync_max_i       resync counter one below max (sampled in IDLE)
//   iretire_i             qualified instruction retired
//   branch_map_cnt_i      unreported branches held in the branch map
//   packet_valid_o        registered packet request
//   packet_format_o       registered format: 01 flush, 11 sync
//   packet_ready_i        packetizer accepts the request
//   packet_emitted_o      valid && ready, feeds the resync counter
//   resync_rst_o          one-cycle pulse after an accepted sync packet
//   resync_pending_o      a sync is owed and not yet accepted
//   timeout_o             one-cycle pulse when a stalled request is abandoned
//
// Configuration:
//   TRDB_RESYNC_TIMEOUT_EN  when defined, a stall watchdog abandons a request
//                           after TIMEOUT_CYCLES stalled cycles and returns
//                           to PENDING; when undefined, timeout_o is 0.

module trdb_resync_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       trace_enabled_i,
    input  logic       gt_resync_max_i,
    input  logic       et_resync_max_i,
    input  logic       iretire_i,
    input  logic [5:0] branch_map_cnt_i,
    output logic       packet_valid_o,
    output logic [1:0] packet_format_o,
    input  logic       packet_ready_i,
    output logic       packet_emitted_o,
    output logic       resync_rst_o,
    output logic       resync_pending_o,
    output logic       timeout_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FLUSH   = 2'd2,
        SYNC    = 2'd3
    } state_e;

    localparam logic [1:0] FMT_NONE  = 2'b00;
    localparam logic [1:0] FMT_FLUSH = 2'b01;
    localparam logic [1:0] FMT_SYNC  = 2'b11;

    state_e     state_q, state_d;
    logic       gt_seen_q, gt_seen_d;
    logic       valid_q, valid_d;
    logic [1:0] format_q, format_d;
    logic       resync_rst_q, resync_rst_d;
    logic       timeout_q, timeout_d;
    logic       handshake;
    logic       stall_expired;

    assign handshake = valid_q && packet_ready_i;

`ifdef TRDB_RESYNC_TIMEOUT_EN
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle.
    assign stall_expired = valid_q && !packet_ready_i && (stall_cnt_q == STALL_LAST);

    always_comb begin
        stall_cnt_d = 16'd0;
        if (valid_q && !packet_ready_i && (state_d == state_q)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign stall_expired      = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d   = state_q;
        gt_seen_d = gt_seen_q;

        unique case (state_q)
            IDLE: begin
                if (trace_enabled_i) begin
                    if (gt_resync_max_i) begin
                        state_d = PENDING;
                    end else if (et_resync_max_i && (branch_map_cnt_i != 6'd0)) begin
                        state_d = FLUSH;
                    end
                end
            end
            PENDING: begin
                // Wait for a retirement so the sync carries a fresh address.
                if (iretire_i) begin
                    state_d = (branch_map_cnt_i != 6'd0) ? FLUSH : SYNC;
                end
            end
            FLUSH: begin
                if (handshake) begin
                    state_d = gt_seen_q ? SYNC : PENDING;
                end else if (stall_expired) begin
                    state_d = PENDING;
                end
            end
            SYNC: begin
                if (handshake) begin
                    state_d = IDLE;
                end else if (stall_expired) begin
                    state_d = PENDING;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!trace_enabled_i) begin
            state_d = IDLE;
        end

        // PENDING always means a sync is owed, so any flush issued from there
        // (including after a pre-emptive flush or a timeout) chains into SYNC.
        if (state_d == IDLE) begin
            gt_seen_d = 1'b0;
        end else if (state_d == PENDING) begin
            gt_seen_d = 1'b1;
        end

        valid_d  = (state_d == FLUSH) || (state_d == SYNC);
        format_d = (state_d == SYNC)  ? FMT_SYNC :
                   (state_d == FLUSH) ? FMT_FLUSH : FMT_NONE;

        // An accepted sync clears the counter even if trace drops that cycle.
        resync_rst_d = handshake && (state_q == SYNC);
        timeout_d    = stall_expired && trace_enabled_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            gt_seen_q    <= 1'b0;
            valid_q      <= 1'b0;
            format_q     <= FMT_NONE;
            resync_rst_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gt_seen_q    <= gt_seen_d;
            valid_q      <= valid_d;
            format_q     <= format_d;
            resync_rst_q <= resync_rst_d;
            timeout_q    <= timeout_d;
        end
    end

    assign packet_valid_o   = valid_q;
    assign packet_format_o  = format_q;
    assign packet_emitted_o = handshake;
    assign resync_rst_o     = resync_rst_q;
    assign timeout_o        = timeout_q;
    assign resync_pending_o = (state_q == PENDING) || (state_q == SYNC) ||
                              ((state_q == FLUSH) && gt_seen_q);

endmodule

// File: tb/tb_trdb_resync_ctrl.sv
// tb/tb_trdb_resync_ctrl.sv - self-checking bench for trdb_resync_ctrl

module tb_trdb_resync_ctrl;

    localparam int LIMIT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trace_enabled;
    logic       gt_max;
    logic       et_max;
    logic       iretire;
    logic [5:0] bmc;
    logic       ready;
    logic       valid;
    logic [1:0] fmt;
    logic       emitted;
    logic       rst_pulse;
    logic       pending;
    logic       tmo;

    int total = 0;
    int bad   = 0;
    logic [6:0] exp;
    wire  [6:0] obs = {valid, fmt, emitted, rst_pulse, pending, tmo};

    trdb_resync_ctrl #(.TIMEOUT_CYCLES(LIMIT)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .trace_enabled_i  (trace_enabled),
        .gt_resync_max_i  (gt_max),
        .et_resync_max_i  (et_max),
        .iretire_i        (iretire),
        .branch_map_cnt_i (bmc),
        .packet_valid_o   (valid),
        .packet_format_o  (fmt),
        .packet_ready_i   (ready),
        .packet_emitted_o (emitted),
        .resync_rst_o     (rst_pulse),
        .resync_pending_o (pending),
        .timeout_o        (tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic te, input logic gt, input logic et, input logic ir,
                         input logic [5:0] b, input logic rdy);
        trace_enabled = te;
        gt_max        = gt;
        et_max        = et;
        iretire       = ir;
        bmc           = b;
        ready         = rdy;
        #1;
    endtask

    // obs = {valid, format[1:0], emitted, resync_rst, pending, timeout}

    task automatic test_reset();
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd5, 1'b1);
        exp = 7'b0_00_0_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_hold got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b0_00_0_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_clocked got=%b want=%b", obs, exp); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        exp = 7'b0_00_0_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_release got=%b want=%b", obs, exp); end
    endtask

    task automatic idle_gap();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_sync_only();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1);
        exp = 7'b0_00_0_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_idle got=%b want=%b", obs, exp); end
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
        exp = 7'b0_00_0_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_pending got=%b want=%b", obs, exp); end
        tick();
        tick();
        exp = 7'b0_00_0_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_wait got=%b want=%b", obs, exp); end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
        exp = 7'b1_11_1_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_offer got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b0_00_0_1_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_rst_pulse got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b0_00_0_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_after got=%b want=%b", obs, exp); end
    endtask

    task automatic test_flush_then_sync();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd5, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd5, 1'b1);
        exp = 7'b0_00_0_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL fs_pending got=%b want=%b", obs, exp); end
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 1'b1);
        exp = 7'b1_01_1_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL fs_flush got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b1_11_1_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL fs_sync got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b0_00_0_1_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL fs_rst got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b0_00_0_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL fs_done got=%b want=%b", obs, exp); end
    endtask

    task automatic test_preempt_stall();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd3, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp = 7'b1_01_0_0_0_0; total++;
            if (obs !== exp) begin bad++; $display("FAIL pre_stall[%0d] got=%b want=%b", i, obs, exp); end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd3, 1'b1);
        exp = 7'b1_01_1_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL pre_accept got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b0_00_0_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL pre_pending got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b0_00_0_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL pre_no_rst got=%b want=%b", obs, exp); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        tick();
        exp = 7'b0_00_0_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL pre_abort got=%b want=%b", obs, exp); end
    endtask

    task automatic test_trace_drop();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        exp = 7'b1_11_0_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL td_stall got=%b want=%b", obs, exp); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        exp = 7'b1_11_0_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL td_drop got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b0_00_0_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL td_idle got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b0_00_0_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL td_quiet got=%b want=%b", obs, exp); end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
        exp = 7'b1_11_1_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL td_hs_drop got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b0_00_0_1_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL td_hs_rst got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b0_00_0_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL td_hs_done got=%b want=%b", obs, exp); end
    endtask

    task automatic test_stall_limit();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
`ifdef TRDB_RESYNC_TIMEOUT_EN
        for (int i = 0; i < LIMIT; i++) begin
            exp = 7'b1_11_0_0_1_0; total++;
            if (obs !== exp) begin bad++; $display("FAIL to_stall[%0d] got=%b want=%b", i, obs, exp); end
            tick();
        end
        exp = 7'b0_00_0_0_1_1; total++;
        if (obs !== exp) begin bad++; $display("FAIL to_pulse got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b0_00_0_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL to_pending got=%b want=%b", obs, exp); end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
        exp = 7'b1_11_1_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL to_retry got=%b want=%b", obs, exp); end
`else
        for (int i = 0; i < 100; i++) begin
            exp = 7'b1_11_0_0_1_0; total++;
            if (obs !== exp) begin bad++; $display("FAIL hold[%0d] got=%b want=%b", i, obs, exp); end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
        exp = 7'b1_11_1_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL hold_accept got=%b want=%b", obs, exp); end
`endif
        tick();
        exp = 7'b0_00_0_1_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL stall_rst got=%b want=%b", obs, exp); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
        exp = 7'b1_11_1_0_1_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL ar_before got=%b want=%b", obs, exp); end
        #2 rst_n = 1'b0;
        #1;
        exp = 7'b0_00_0_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL ar_async got=%b want=%b", obs, exp); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
        tick();
        exp = 7'b0_00_0_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL ar_idle got=%b want=%b", obs, exp); end
        tick();
        exp = 7'b0_00_0_0_0_0; total++;
        if (obs !== exp) begin bad++; $display("FAIL ar_quiet got=%b want=%b", obs, exp); end
    endtask

    // Reference model: offer = format currently requested (0 none), owed =
    // a sync is owed, await = waiting for a retirement before requesting.
    task automatic test_random();
        logic [1:0] m_offer = 2'b00;
        logic       m_owed  = 1'b0;
        logic       m_await = 1'b0;
        logic       m_rst   = 1'b0;
        logic       m_tmo   = 1'b0;
        int         m_stall = 0;
        logic       te, gt, et, ir, rdy, hs, n_rst, n_tmo;
        logic [5:0] b;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            te  = ($urandom_range(0, 15) != 0);
            gt  = ($urandom_range(0, 5) == 0);
            et  = ($urandom_range(0, 4) == 0);
            ir  = ($urandom_range(0, 2) == 0);
            b   = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(1, 31));
            rdy = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
            drive(te, gt, et, ir, b, rdy);

            exp = {m_offer != 2'b00, m_offer, (m_offer != 2'b00) && rdy, m_rst, m_owed, m_tmo};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL rand[%0d] got=%b want=%b", i, obs, exp); end

            hs    = (m_offer != 2'b00) && rdy;
            n_rst = hs && (m_offer == 2'b11);
            n_tmo = 1'b0;
            if (!te) begin
                m_offer = 2'b00; m_owed = 1'b0; m_await = 1'b0; m_stall = 0;
            end else if (hs) begin
                m_stall = 0;
                if (m_offer == 2'b11) begin
                    m_offer = 2'b00; m_owed = 1'b0;
                end else if (m_owed) begin
                    m_offer = 2'b11;
                end else begin
                    m_offer = 2'b00; m_owed = 1'b1; m_await = 1'b1;
                end
            end else if (m_offer != 2'b00) begin
                m_stall++;
`ifdef TRDB_RESYNC_TIMEOUT_EN
                if (m_stall == LIMIT) begin
                    m_offer = 2'b00; m_owed = 1'b1; m_await = 1'b1; m_stall = 0; n_tmo = 1'b1;
                end
`endif
            end else if (m_await) begin
                if (ir) begin
                    m_await = 1'b0;
                    m_offer = (b != 6'd0) ? 2'b01 : 2'b11;
                end
            end else if (gt) begin
                m_owed = 1'b1; m_await = 1'b1;
            end else if (et && (b != 6'd0)) begin
                m_offer = 2'b01;
            end
            m_rst = n_rst;
            m_tmo = n_tmo;
            tick();
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        test_reset();
        idle_gap();
        test_sync_only();
        idle_gap();
        test_flush_then_sync();
        idle_gap();
        test_preempt_stall();
        idle_gap();
        test_trace_drop();
        idle_gap();
        test_stall_limit();
        idle_gap();
        test_async_reset();
        idle_gap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
